// File: rtl/d_mem_axi_slave_pkg.sv
// Shared types and constants for the data-side AXI memory slave.
// Holds response codes, FSM encodings and the default geometry.
package d_mem_axi_slave_pkg;

   localparam int unsigned DEF_XLEN     = 32;
   localparam int unsigned DEF_D_WORD   = 4;
   localparam int unsigned DEF_DEPTH    = 1024;
   localparam int unsigned DEF_READ_LAT = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_FETCH,
      R_RESP
   } r_state_e;

   // Byte-address bits covered by one cache line.
   function automatic int unsigned line_off_bits(input int unsigned d_word);
      return $clog2(d_word) + 2;
   endfunction

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/d_mem_array.sv
// Single-port word RAM with per-byte write enables and registered read data.
// A write and a read never share a cycle; the top arbitrates the port.
module d_mem_array #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     clk_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [XLEN/8-1:0]        we_i,
   input  logic                     re_i,
   input  logic [XLEN-1:0]          wdata_i,
   output logic [XLEN-1:0]          rdata_o
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   // NOTE: the storage array and its read register have no reset; clearing a
   // RAM is not something the macro can do, so no reset term is modelled.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < XLEN / 8; b++) begin
         if (we_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/d_mem_axi_slave.sv
// AXI-style data memory slave: line refills on the read side, strobed
// single-word write-throughs on the write side, sharing one RAM port.
module d_mem_axi_slave
   import d_mem_axi_slave_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned D_WORD   = DEF_D_WORD,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned READ_LAT = DEF_READ_LAT
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic                   S_AWVALID,
   input  logic [XLEN-1:0]        S_AWADDR,
   output logic                   S_AWREADY,
   input  logic                   S_WVALID,
   input  logic [XLEN-1:0]        S_WDATA,
   input  logic [XLEN/8-1:0]      S_WSTRB,
   output logic                   S_WREADY,
   output logic                   S_BVALID,
   output logic [1:0]             S_BRESP,
   input  logic                   S_BREADY,
   input  logic                   S_ARVALID,
   input  logic [XLEN-1:0]        S_ARADDR,
   output logic                   S_ARREADY,
   output logic                   S_RVALID,
   output logic [XLEN*D_WORD-1:0] S_RDATA,
   output logic [1:0]             S_RRESP,
   input  logic                   S_RREADY
);

   localparam int unsigned OFF_W  = $clog2(D_WORD);
   localparam int unsigned LINE_W = line_off_bits(D_WORD);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam logic [3:0]  LAT_M1 = (READ_LAT > 0) ? 4'(READ_LAT - 1) : 4'd0;

   // Any set bit above the index field puts the word beyond the array.
   function automatic logic addr_err(input logic [XLEN-1:0] a);
      return |a[XLEN-1:IDX_W+2];
   endfunction

   w_state_e              w_state_q;
   logic                  aw_full_q, w_full_q, aw_ready_q, w_ready_q, aw_err_q;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [XLEN-1:0]       wdata_q;
   logic [XLEN/8-1:0]     wstrb_q;
   logic                  b_valid_q;
   logic [1:0]            b_resp_q;

   r_state_e              r_state_q;
   logic                  ar_ready_q, r_err_q, rd_pend_q, r_valid_q;
   logic [IDX_W-OFF_W-1:0] base_q;
   logic [3:0]            wait_q;
   logic [OFF_W:0]        fetch_cnt_q;
   logic [OFF_W-1:0]      rd_idx_q;
   logic [XLEN*D_WORD-1:0] line_q;
   logic [1:0]            r_resp_q;

   logic                  aw_hs, w_hs, ar_hs, commit, fetch_issue;
   logic [IDX_W-1:0]      ram_addr;
   logic [XLEN/8-1:0]     ram_we;
   logic [XLEN-1:0]       ram_rdata;
   logic                  unused_addr_bits;

   assign aw_hs  = S_AWVALID && aw_ready_q;
   assign w_hs   = S_WVALID && w_ready_q;
   assign ar_hs  = S_ARVALID && ar_ready_q;
   assign commit = (w_state_q == W_COMMIT);

   // The commit owns the port; a fetch in the same cycle waits one cycle.
   assign fetch_issue = (r_state_q == R_FETCH) && !fetch_cnt_q[OFF_W] && !commit;
   assign ram_we      = (commit && !aw_err_q) ? wstrb_q : '0;
   assign ram_addr    = commit ? aw_idx_q : {base_q, fetch_cnt_q[OFF_W-1:0]};

   assign unused_addr_bits = ^{S_AWADDR[1:0], S_ARADDR[LINE_W-1:0]};

   d_mem_array #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (CLK),
      .addr_i  (ram_addr),
      .we_i    (ram_we),
      .re_i    (fetch_issue),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // NOTE: state registers use non-blocking assignment only, so every branch
   // reads the pre-edge value of every register regardless of statement order.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= W_IDLE;
         aw_full_q  <= 1'b0;
         w_full_q   <= 1'b0;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         aw_err_q   <= 1'b0;
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= RESP_OKAY;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               aw_ready_q <= !(aw_full_q || aw_hs);
               w_ready_q  <= !(w_full_q || w_hs);
               if (aw_hs) begin
                  aw_full_q <= 1'b1;
                  aw_idx_q  <= S_AWADDR[IDX_W+1:2];
                  aw_err_q  <= addr_err(S_AWADDR);
               end
               if (w_hs) begin
                  w_full_q <= 1'b1;
                  wdata_q  <= S_WDATA;
                  wstrb_q  <= S_WSTRB;
               end
               if (aw_full_q && w_full_q) begin
                  w_state_q <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               w_state_q <= W_RESP;
               b_valid_q <= 1'b1;
               b_resp_q  <= resp_of(aw_err_q);
            end
            W_RESP: begin
               if (S_BREADY) begin
                  w_state_q  <= W_IDLE;
                  b_valid_q  <= 1'b0;
                  aw_full_q  <= 1'b0;
                  w_full_q   <= 1'b0;
                  aw_ready_q <= 1'b1;
                  w_ready_q  <= 1'b1;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q   <= R_IDLE;
         ar_ready_q  <= 1'b0;
         r_err_q     <= 1'b0;
         base_q      <= '0;
         wait_q      <= '0;
         fetch_cnt_q <= '0;
         rd_pend_q   <= 1'b0;
         rd_idx_q    <= '0;
         line_q      <= '0;
         r_valid_q   <= 1'b0;
         r_resp_q    <= RESP_OKAY;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               ar_ready_q <= !ar_hs;
               if (ar_hs) begin
                  base_q      <= S_ARADDR[IDX_W+1:LINE_W];
                  r_err_q     <= addr_err(S_ARADDR);
                  wait_q      <= '0;
                  fetch_cnt_q <= '0;
                  r_state_q   <= (READ_LAT == 0) ? R_FETCH : R_WAIT;
               end
            end
            R_WAIT: begin
               if (wait_q == LAT_M1) begin
                  r_state_q <= R_FETCH;
               end else begin
                  wait_q <= wait_q + 4'd1;
               end
            end
            R_FETCH: begin
               // RAM data lands one cycle after its address; capture it then.
               rd_pend_q <= fetch_issue;
               if (rd_pend_q) begin
                  line_q[rd_idx_q*XLEN +: XLEN] <= r_err_q ? '0 : ram_rdata;
               end
               if (fetch_issue) begin
                  rd_idx_q    <= fetch_cnt_q[OFF_W-1:0];
                  fetch_cnt_q <= fetch_cnt_q + 1'b1;
               end
               if (fetch_cnt_q[OFF_W]) begin
                  r_state_q <= R_RESP;
                  r_valid_q <= 1'b1;
                  r_resp_q  <= resp_of(r_err_q);
               end
            end
            R_RESP: begin
               if (S_RREADY) begin
                  r_state_q  <= R_IDLE;
                  r_valid_q  <= 1'b0;
                  ar_ready_q <= 1'b1;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign S_AWREADY = aw_ready_q;
   assign S_WREADY  = w_ready_q;
   assign S_BVALID  = b_valid_q;
   assign S_BRESP   = b_resp_q;
   assign S_ARREADY = ar_ready_q;
   assign S_RVALID  = r_valid_q;
   assign S_RDATA   = line_q;
   assign S_RRESP   = r_resp_q;

endmodule

// File: tb/tb_d_mem_axi_slave.sv
// Directed bench for d_mem_axi_slave: write/read timing, strobes, SLVERR,
// backpressure, port collision and asynchronous reset.
module tb_d_mem_axi_slave;

   logic         CLK = 1'b0;
   logic         rst_n;
   logic         S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
   logic         S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
   logic [31:0]  S_AWADDR, S_WDATA, S_ARADDR;
   logic [3:0]   S_WSTRB;
   logic [1:0]   S_BRESP, S_RRESP;
   logic [127:0] S_RDATA;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   d_mem_axi_slave dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .S_AWVALID (S_AWVALID),
      .S_AWADDR  (S_AWADDR),
      .S_AWREADY (S_AWREADY),
      .S_WVALID  (S_WVALID),
      .S_WDATA   (S_WDATA),
      .S_WSTRB   (S_WSTRB),
      .S_WREADY  (S_WREADY),
      .S_BVALID  (S_BVALID),
      .S_BRESP   (S_BRESP),
      .S_BREADY  (S_BREADY),
      .S_ARVALID (S_ARVALID),
      .S_ARADDR  (S_ARADDR),
      .S_ARREADY (S_ARREADY),
      .S_RVALID  (S_RVALID),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RREADY  (S_RREADY)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_wr_ready();
      int n = 0;
      while (!(S_AWREADY && S_WREADY) && n < 20) begin
         tick();
         n++;
      end
      check("wr_ready_wait", 128'(n < 20), 128'd1);
   endtask

   task automatic wait_ar_ready();
      int n = 0;
      while (!S_ARREADY && n < 20) begin
         tick();
         n++;
      end
      check("ar_ready_wait", 128'(n < 20), 128'd1);
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n = 0;
      wait_wr_ready();
      S_AWVALID = 1'b1; S_AWADDR = a;
      S_WVALID  = 1'b1; S_WDATA  = d; S_WSTRB = s;
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      while (!S_BVALID && n < 20) begin
         tick();
         n++;
      end
      check("b_wait", 128'(n < 20), 128'd1);
      resp = S_BRESP;
      tick();
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [127:0] data,
                           output logic [1:0] resp, output int lat);
      wait_ar_ready();
      S_ARVALID = 1'b1; S_ARADDR = a;
      tick();
      S_ARVALID = 1'b0;
      lat = 0;
      while (!S_RVALID && lat < 40) begin
         tick();
         lat++;
      end
      data = S_RDATA;
      resp = S_RRESP;
      if (S_RREADY) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_arready"}, 128'(S_ARREADY), 128'd0);
      check({tag, "_awready"}, 128'(S_AWREADY), 128'd0);
      check({tag, "_wready"},  128'(S_WREADY),  128'd0);
      check({tag, "_rvalid"},  128'(S_RVALID),  128'd0);
      check({tag, "_bvalid"},  128'(S_BVALID),  128'd0);
      check({tag, "_rdata"},   S_RDATA,         128'd0);
      check({tag, "_rresp"},   128'(S_RRESP),   128'd0);
      check({tag, "_bresp"},   128'(S_BRESP),   128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] rd;
      logic [1:0]   rr, br;
      int           lat, n;
      bit           saw_b;

      rst_n = 1'b0;
      S_AWVALID = 1'b0; S_AWADDR = '0; S_WVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0;
      S_ARVALID = 1'b0; S_ARADDR = '0; S_BREADY = 1'b1; S_RREADY = 1'b1;
      #3;
      check_all_zero("reset");
      tick(); tick();
      @(negedge CLK);
      rst_n = 1'b1;
      tick(); tick();
      check("idle_awready", 128'(S_AWREADY), 128'd1);
      check("idle_arready", 128'(S_ARREADY), 128'd1);

      // 1: AW and W together; B rises on the third edge counting the handshake.
      S_AWVALID = 1'b1; S_AWADDR = 32'h10;
      S_WVALID  = 1'b1; S_WDATA  = 32'hDEADBEEF; S_WSTRB = 4'hF;
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      check("t1_bvalid_e0", 128'(S_BVALID), 128'd0);
      tick();
      check("t1_bvalid_e1", 128'(S_BVALID), 128'd0);
      tick();
      check("t1_bvalid_e2", 128'(S_BVALID), 128'd1);
      check("t1_bresp", 128'(S_BRESP), 128'd0);
      tick();
      check("t1_bvalid_done", 128'(S_BVALID), 128'd0);
      axi_read(32'h10, rd, rr, lat);
      check("t1_rlat", 128'(lat), 128'd7);
      check("t1_word0", 128'(rd[31:0]), 128'hDEADBEEF);
      check("t1_rresp", 128'(rr), 128'd0);

      // 2: fill a line, read from a mid-line address
      axi_write(32'h20, 32'h11111111, 4'hF, br);
      axi_write(32'h24, 32'h22222222, 4'hF, br);
      axi_write(32'h28, 32'h33333333, 4'hF, br);
      axi_write(32'h2C, 32'h44444444, 4'hF, br);
      check("t2_bresp", 128'(br), 128'd0);
      axi_read(32'h28, rd, rr, lat);
      check("t2_line", rd, 128'h44444444_33333333_22222222_11111111);
      check("t2_rresp", 128'(rr), 128'd0);

      // 3: partial strobe, W three cycles ahead of AW
      axi_write(32'h40, 32'h00000000, 4'hF, br);
      wait_wr_ready();
      S_WVALID = 1'b1; S_WDATA = 32'hAABBCCDD; S_WSTRB = 4'h5;
      tick();
      S_WVALID = 1'b0;
      check("t3_wready_full", 128'(S_WREADY), 128'd0);
      check("t3_awready_open", 128'(S_AWREADY), 128'd1);
      check("t3_no_b_e0", 128'(S_BVALID), 128'd0);
      tick();
      check("t3_no_b_e1", 128'(S_BVALID), 128'd0);
      tick();
      check("t3_no_b_e2", 128'(S_BVALID), 128'd0);
      S_AWVALID = 1'b1; S_AWADDR = 32'h40;
      tick();
      S_AWVALID = 1'b0;
      n = 0;
      while (!S_BVALID && n < 20) begin
         tick();
         n++;
      end
      check("t3_b_seen", 128'(S_BVALID), 128'd1);
      check("t3_bresp", 128'(S_BRESP), 128'd0);
      tick();
      check("t3_b_single", 128'(S_BVALID), 128'd0);
      axi_read(32'h40, rd, rr, lat);
      check("t3_word0", 128'(rd[31:0]), 128'h00BB00DD);

      // 4: out of range; 0x1000 aliases word 0 if the error were ignored
      axi_write(32'h0, 32'hCAFEF00D, 4'hF, br);
      axi_read(32'h1000, rd, rr, lat);
      check("t4_rresp", 128'(rr), 128'd2);
      check("t4_rdata", rd, 128'd0);
      check("t4_rlat", 128'(lat), 128'd7);
      axi_write(32'h1000, 32'h12345678, 4'hF, br);
      check("t4_bresp", 128'(br), 128'd2);
      axi_read(32'h0, rd, rr, lat);
      check("t4_unchanged", 128'(rd[31:0]), 128'hCAFEF00D);
      check("t4_rresp_ok", 128'(rr), 128'd0);

      // 5: RREADY held low while a write completes
      S_RREADY = 1'b0;
      wait_ar_ready();
      S_ARVALID = 1'b1; S_ARADDR = 32'h20;
      tick();
      S_ARVALID = 1'b0;
      n = 0;
      while (!S_RVALID && n < 40) begin
         tick();
         n++;
      end
      check("t5_rlat", 128'(n), 128'd7);
      check("t5_awready", 128'(S_AWREADY), 128'd1);
      S_AWVALID = 1'b1; S_AWADDR = 32'h60;
      S_WVALID  = 1'b1; S_WDATA  = 32'h5A5A5A5A; S_WSTRB = 4'hF;
      saw_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) begin
            S_AWVALID = 1'b0; S_WVALID = 1'b0;
         end
         if (S_BVALID) saw_b = 1'b1;
         check("t5_rvalid_hold", 128'(S_RVALID), 128'd1);
         check("t5_rdata_hold", S_RDATA, 128'h44444444_33333333_22222222_11111111);
         check("t5_arready_low", 128'(S_ARREADY), 128'd0);
      end
      check("t5_write_done", 128'(saw_b), 128'd1);
      check("t5_b_cleared", 128'(S_BVALID), 128'd0);
      S_RREADY = 1'b1;
      tick();
      check("t5_rvalid_drop", 128'(S_RVALID), 128'd0);
      axi_read(32'h60, rd, rr, lat);
      check("t5_word0", 128'(rd[31:0]), 128'h5A5A5A5A);

      // Collision: commit lands inside the fetch of the same line
      wait_ar_ready();
      S_ARVALID = 1'b1; S_ARADDR = 32'h60;
      tick();
      S_ARVALID = 1'b0;
      tick();
      check("col_awready", 128'(S_AWREADY), 128'd1);
      S_AWVALID = 1'b1; S_AWADDR = 32'h64;
      S_WVALID  = 1'b1; S_WDATA  = 32'h77777777; S_WSTRB = 4'hF;
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      lat = 2;
      while (!S_RVALID && lat < 40) begin
         tick();
         lat++;
      end
      rd = S_RDATA;
      check("col_rlat", 128'(lat), 128'd8);
      check("col_word0", 128'(rd[31:0]), 128'h5A5A5A5A);
      check("col_word1_new", 128'(rd[63:32]), 128'h77777777);
      check("col_b_done", 128'(S_BVALID), 128'd0);
      tick();

      // 6: asynchronous reset while the read waits
      wait_ar_ready();
      S_ARVALID = 1'b1; S_ARADDR = 32'h20;
      tick();
      S_ARVALID = 1'b0;
      check("t6_in_wait", 128'(S_ARREADY), 128'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_reset");
      tick();
      @(negedge CLK);
      rst_n = 1'b1;
      tick(); tick();
      axi_read(32'h24, rd, rr, lat);
      check("t6_rlat", 128'(lat), 128'd7);
      check("t6_line", rd, 128'h44444444_33333333_22222222_11111111);
      check("t6_rresp", 128'(rr), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/d_mem_axi_slave.md
Name: d_mem_axi_slave

Overview:
AXI-style memory slave that sits directly downstream of the core's data-cache AXI master port. It serves line refills, returning D_WORD XLEN-bit words in one beat, and single-word write-throughs with byte strobes. The backing store is an internal single-port word array. It replaces bench-driven D-cache stimulus in core-level integration and doubles as the on-chip data RAM model.

Parameters:
XLEN, 32, data word width in bits
D_WORD, 4, words per cache line (power of 2); RDATA width = XLEN*D_WORD
DEPTH, 1024, number of XLEN words in the array (power of 2)
READ_LAT, 2, extra wait cycles before a line fetch starts (0..15)

Ports:
CLK  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
S_AWVALID  in  1  write address valid
S_AWADDR  in  XLEN  write byte address
S_AWREADY  out  1  write address ready
S_WVALID  in  1  write data valid
S_WDATA  in  XLEN  write data
S_WSTRB  in  4  byte enables; bit i covers WDATA[8i+7:8i]
S_WREADY  out  1  write data ready
S_BVALID  out  1  write response valid
S_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
S_BREADY  in  1  write response ready
S_ARVALID  in  1  read address valid
S_ARADDR  in  XLEN  read byte address
S_ARREADY  out  1  read address ready
S_RVALID  out  1  read line valid
S_RDATA  out  XLEN*D_WORD  line data; word k at [XLEN*(k+1)-1:XLEN*k]
S_RRESP  out  2  read response
S_RREADY  in  1  read line ready

Behaviour:
- Reset (async assert, sync release): all READY/VALID outputs 0, RESP 2'b00, RDATA 0, FSMs idle, latches empty. Array contents are not reset.
- Word index = ADDR[log2(DEPTH)+1:2]. Out of range when ADDR[XLEN-1:2] >= DEPTH → SLVERR.
- Write channel:
  - AW and W are independent. AWREADY=1 while the AW latch is empty and the write FSM is not in W_RESP; WREADY is the same rule for the W latch.
  - Either order, or the same cycle, is legal.
  - W_IDLE → W_COMMIT once both latches are full. In W_COMMIT, one cycle, the array write applies per WSTRB; there is no write on SLVERR or WSTRB=0.
  - W_COMMIT → W_RESP with BVALID=1, held with BRESP stable until BREADY. Then the latches clear → W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On ARVALID, latch the line base (low log2(D_WORD)+2 bits cleared) and the error flag → R_WAIT.
  - R_WAIT: count READ_LAT cycles; skipped if 0 → R_FETCH.
  - R_FETCH: read one word per cycle, k=0..D_WORD-1, into a line buffer → R_RESP.
  - R_RESP: RVALID=1, RDATA/RRESP stable until RREADY → R_IDLE. ARREADY=0 outside R_IDLE.
  - On SLVERR, the fetch still takes its cycles but RDATA=0 and RRESP=2'b10.
- Latency: AR handshake at edge 0 → RVALID visible after READ_LAT+D_WORD+1 edges (7 with defaults), plus 1 per array-port collision.
- Array port arbitration: W_COMMIT has priority over R_FETCH. The fetch holds its word counter for that cycle. A commit and a fetch to the same word: the read returns the new data.
- Backpressure: RREADY or BREADY held low stalls only its own channel. The other channel continues.
- Reset mid-transaction: all pending transactions are dropped with no response. A partially committed write is not possible, because the commit is single-cycle.

Decomposition:
- Shared package: RESP_OKAY/RESP_SLVERR constants, read/write FSM state encodings, localparams for line offset bits and index width.
- One sub-module: d_mem_array, a single-port DEPTH×XLEN RAM with byte-write enable and synchronous read.

Test Plan:
1. Write AW=0x10 and W=0xDEADBEEF with WSTRB=4'hF in the same cycle; BREADY=1 → BVALID with BRESP=00 three edges later. A read at AR=0x10 returns RDATA word0=0xDEADBEEF, with RVALID 7 edges after the AR handshake.
2. Fill 0x20..0x2C with 0x11111111..0x44444444, then read AR=0x28 → RDATA=0x44444444_33333333_22222222_11111111 (line-aligned).
3. Write 0xAABBCCDD at 0x40 with WSTRB=4'h5 over 0x00000000 → the read returns 0x00BB00DD. W sent 3 cycles before AW → a single BVALID only after AW arrives.
4. Read AR=0x1000 (DEPTH=1024) → RRESP=10, RDATA=0. Write to 0x1000 → BRESP=10, and the array is unchanged on readback.
5. Hold RREADY=0 for 10 cycles → RVALID/RDATA stay stable and ARREADY=0. Meanwhile a write completes with BVALID.
6. Assert rst_n=0 during R_WAIT → all outputs return to 0 asynchronously. After release, a fresh read returns correct data.
